// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the shared RAM arbiter: per-port request fields in,
// per-port grant/ack plus the shared read data and busy flag out.
interface ram_arbiter_if #(
  parameter int N_PORTS    = 3,
  parameter int ADDR_WIDTH = 8,
  parameter int WIDTH      = 32
);
  logic [N_PORTS-1:0]            req;
  logic [N_PORTS-1:0]            we;
  logic [N_PORTS*ADDR_WIDTH-1:0] addr;
  logic [N_PORTS*WIDTH-1:0]      wdata;
  logic [N_PORTS*WIDTH/8-1:0]    be;
  logic [N_PORTS-1:0]            gnt;
  logic [N_PORTS-1:0]            ack;
  logic [WIDTH-1:0]              rdata;
  logic                          busy;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, ack, rdata, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, ack, rdata, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter that owns the single word-wide RAM; sub-word stores are
// performed as read-modify-write because the RAM only writes whole words.
module ram_arbiter #(
  parameter int N_PORTS    = 3,
  parameter int ADDR_WIDTH = 8,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  ram_arbiter_if.slave          bus,
  output logic                  ram_wr_enable,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [WIDTH-1:0]      ram_data_in,
  input  logic [WIDTH-1:0]      ram_data_out
);

  localparam int BW = WIDTH / 8;
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

  state_t               state;
  logic [PW-1:0]        last_grant;
  logic [PW-1:0]        port_id;
  logic                 we_l;
  logic [WIDTH-1:0]     wdata_l;
  logic [BW-1:0]        be_l;

  logic [N_PORTS-1:0]   gnt_r;
  logic [N_PORTS-1:0]   ack_r;
  logic [WIDTH-1:0]     rdata_r;
  logic                 busy_r;

  logic [PW:0]          pick;
  logic [PW-1:0]        sel;
  logic                 sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]     sel_wdata;
  logic [BW-1:0]        sel_be;

  // MSB of the result flags "some port requested"; the low bits are the winner.
  function automatic logic [PW:0] pick_port(input logic [N_PORTS-1:0] r,
                                            input logic [PW-1:0]      last);
    logic [PW:0] res;
    int          idx;
    res = '0;
    // Scan from the farthest offset down so the nearest requester wins.
    for (int i = N_PORTS; i >= 1; i--) begin
      idx = (int'(last) + i) % N_PORTS;
      if (r[idx]) res = {1'b1, PW'(idx)};
    end
    return res;
  endfunction

  function automatic logic [N_PORTS-1:0] port_onehot(input logic [PW-1:0] id);
    logic [N_PORTS-1:0] v;
    v = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (id == PW'(p)) v[p] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] byte_merge(input logic [WIDTH-1:0] old_w,
                                                  input logic [WIDTH-1:0] new_w,
                                                  input logic [BW-1:0]    en);
    logic [WIDTH-1:0] m;
    for (int k = 0; k < BW; k++) begin
      m[k*8 +: 8] = en[k] ? new_w[k*8 +: 8] : old_w[k*8 +: 8];
    end
    return m;
  endfunction

  always_comb begin
    pick      = pick_port(bus.req, last_grant);
    sel       = pick[PW-1:0];
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (sel == PW'(p)) begin
        sel_we    = bus.we[p];
        sel_addr  = bus.addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.wdata[p*WIDTH +: WIDTH];
        sel_be    = bus.be[p*BW +: BW];
      end
    end
  end

  // Transaction request fields are captured at grant and never reset: they
  // are only consumed after IDLE has reloaded them.
  always_ff @(posedge clk) begin
    if (state == IDLE && pick[PW]) begin
      port_id <= sel;
      we_l    <= sel_we;
      wdata_l <= sel_wdata;
      be_l    <= sel_be;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      last_grant    <= PW'(N_PORTS - 1);
      gnt_r         <= '0;
      ack_r         <= '0;
      rdata_r       <= '0;
      busy_r        <= 1'b0;
      ram_wr_enable <= 1'b0;
      ram_rd_addr   <= '0;
      ram_wr_addr   <= '0;
      ram_data_in   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick[PW]) begin
            ram_rd_addr <= sel_addr;
            ram_wr_addr <= sel_addr;
            last_grant  <= sel;
            gnt_r       <= port_onehot(sel);
            busy_r      <= 1'b1;
            if (sel_we && (&sel_be)) begin
              ram_data_in   <= sel_wdata;
              ram_wr_enable <= 1'b1;
              state         <= WR;
            end else begin
              state <= RD;
            end
          end
        end

        RD: begin
          if (!we_l) begin
            rdata_r <= ram_data_out;
            ack_r   <= port_onehot(port_id);
            state   <= ACK;
          end else if (be_l == '0) begin
            ack_r <= port_onehot(port_id);
            state <= ACK;
          end else begin
            ram_data_in   <= byte_merge(ram_data_out, wdata_l, be_l);
            ram_wr_enable <= 1'b1;
            state         <= WR;
          end
        end

        // RAM commits on the edge that leaves this state.
        WR: begin
          ram_wr_enable <= 1'b0;
          ack_r         <= port_onehot(port_id);
          state         <= ACK;
        end

        ACK: begin
          ack_r  <= '0;
          gnt_r  <= '0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt   = gnt_r;
  assign bus.ack   = ack_r;
  assign bus.rdata = rdata_r;
  assign bus.busy  = busy_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a transaction-level model predicts grant
// order, read data and memory contents; a negedge monitor checks every ack.
module tb_ram_arbiter;
  localparam int N  = 3;
  localparam int AW = 8;
  localparam int W  = 32;
  localparam int BW = W / 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.N_PORTS(N), .ADDR_WIDTH(AW), .WIDTH(W)) bus ();

  logic          ram_wr_enable;
  logic [AW-1:0] ram_rd_addr;
  logic [AW-1:0] ram_wr_addr;
  logic [W-1:0]  ram_data_in;
  logic [W-1:0]  ram_data_out;

  ram_arbiter #(.N_PORTS(N), .ADDR_WIDTH(AW), .WIDTH(W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .bus          (bus),
    .ram_wr_enable(ram_wr_enable),
    .ram_rd_addr  (ram_rd_addr),
    .ram_wr_addr  (ram_wr_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  // Behavioural RAM: combinational read, write on the clock edge.
  logic [W-1:0]  ram [0:255];
  logic          init_en = 1'b0;
  logic          pl_en   = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [W-1:0]  pl_data = '0;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h01000193) ^ 32'h5A5AA5A5;
  endfunction

  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end
    if (ram_wr_enable) ram[ram_wr_addr] <= ram_data_in;
  end
  assign ram_data_out = ram[ram_rd_addr];

  // Reference model state
  logic [31:0] mdl_mem [0:255];
  int          mdl_last  = N - 1;
  logic [31:0] mdl_rdata = '0;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int wr_cnt = 0;

  logic [N-1:0] prev_gnt = '0;
  logic [N-1:0] prev_ack = '0;
  int           gstart   = 0;

  always @(negedge clk) begin
    exp_t         e;
    logic [N-1:0] oh;
    cyc++;
    if (ram_wr_enable) wr_cnt++;
    if (bus.gnt != '0 && prev_gnt == '0) gstart = cyc;
    if (rstn && prev_ack != '0) begin
      checks++;
      if (bus.gnt !== '0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL bubble: gnt=%b busy=%b, required gnt=0 busy=0", bus.gnt, bus.busy);
      end
    end
    if (bus.ack != '0) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: ack=%b, required no ack", bus.ack);
      end else begin
        e  = sbq.pop_front();
        oh = N'(1) << e.port;
        if (bus.ack !== oh || bus.gnt !== oh || bus.rdata !== e.rdata || (cyc - gstart) != e.lat) begin
          errors++;
          $display("FAIL ack_check: ack=%b gnt=%b rdata=%h lat=%0d, required ack=gnt=%b rdata=%h lat=%0d",
                   bus.ack, bus.gnt, bus.rdata, cyc - gstart, oh, e.rdata, e.lat);
        end
      end
    end
    prev_gnt = bus.gnt;
    prev_ack = bus.ack;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input int n);
    rstn = 1'b0;
    repeat (n) tick();
    rstn      = 1'b1;
    mdl_last  = N - 1;
    mdl_rdata = '0;
  endtask

  task automatic set_port(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [W-1:0] d, input logic [BW-1:0] b);
    bus.we[p]             = w;
    bus.addr[p*AW +: AW]  = a;
    bus.wdata[p*W +: W]   = d;
    bus.be[p*BW +: BW]    = b;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    tick();
    pl_en      = 1'b0;
    mdl_mem[a] = d;
  endtask

  function automatic logic [31:0] merge_ref(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] b);
    logic [31:0] mask;
    mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    return (new_w & mask) | (old_w & ~mask);
  endfunction

  task automatic check_mem(input string name);
    int bad;
    int first;
    bad   = 0;
    first = -1;
    for (int i = 0; i < 256; i++) begin
      if (ram[i] !== mdl_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s mem: %0d words differ, first addr %0d got %h, required %h",
               name, bad, first, ram[first], mdl_mem[first]);
    end
  endtask

  // Issues one request per port in mask simultaneously and waits for all acks.
  task automatic run_round(input logic [N-1:0] mask);
    int           order[$];
    int           p;
    int           exp_wr;
    int           wr0;
    int           budget;
    logic [N-1:0] scr;
    logic [N-1:0] pend;
    logic         w;
    logic [AW-1:0] a;
    logic [W-1:0] d;
    logic [BW-1:0] b;
    exp_t         e;
    exp_wr = 0;
    for (int i = 1; i <= N; i++) begin
      p = (mdl_last + i) % N;
      if (mask[p]) order.push_back(p);
    end
    foreach (order[k]) begin
      p = order[k];
      w = bus.we[p];
      a = bus.addr[p*AW +: AW];
      d = bus.wdata[p*W +: W];
      b = bus.be[p*BW +: BW];
      e.port = p;
      e.lat  = 1;
      if (!w) begin
        mdl_rdata = mdl_mem[a];
      end else if (b == 4'hF) begin
        mdl_mem[a] = d;
        exp_wr++;
      end else if (b != 4'h0) begin
        mdl_mem[a] = merge_ref(mdl_mem[a], d, b);
        e.lat = 2;
        exp_wr++;
      end
      e.rdata = mdl_rdata;
      sbq.push_back(e);
    end
    mdl_last = order[order.size()-1];
    wr0      = wr_cnt;
    scr      = '0;
    bus.req  = mask;
    tick();
    checks++;
    if (bus.gnt !== (N'(1) << order[0])) begin
      errors++;
      $display("FAIL grant_order: gnt=%b, required %b", bus.gnt, N'(1) << order[0]);
    end
    pend   = mask;
    budget = 0;
    while (pend != '0 && budget < 60) begin
      for (int q = 0; q < N; q++) begin
        if (bus.gnt[q] && !scr[q]) begin
          scr[q] = 1'b1;
          set_port(q, 1'($urandom), AW'($urandom), $urandom, BW'($urandom));
        end
        if (bus.ack[q]) begin
          bus.req[q] = 1'b0;
          pend[q]    = 1'b0;
        end
      end
      if (pend != '0) tick();
      budget++;
    end
    if (pend != '0) begin
      checks++;
      errors++;
      $display("FAIL timeout: pending ports %b, required all acked", pend);
      bus.req = '0;
      sbq.delete();
      reset_dut(2);
    end
    tick();
    checks++;
    if (wr_cnt - wr0 != exp_wr) begin
      errors++;
      $display("FAIL wr_pulses: got %0d, required %0d", wr_cnt - wr0, exp_wr);
    end
    check_mem("round");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int            wr0;
    logic [N-1:0]  m;
    logic [BW-1:0] b;
    int            r;
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.be    = '0;
    for (int i = 0; i < 256; i++) mdl_mem[i] = init_word(i);
    init_en = 1'b1;
    reset_dut(3);
    init_en = 1'b0;

    checks++;
    if (bus.gnt !== '0 || bus.ack !== '0 || bus.rdata !== '0 || bus.busy !== 1'b0 ||
        ram_wr_enable !== 1'b0 || ram_rd_addr !== '0 || ram_wr_addr !== '0 || ram_data_in !== '0) begin
      errors++;
      $display("FAIL reset_state: gnt=%b ack=%b rdata=%h busy=%b we=%b ra=%h wa=%h di=%h, required all zero",
               bus.gnt, bus.ack, bus.rdata, bus.busy, ram_wr_enable, ram_rd_addr, ram_wr_addr, ram_data_in);
    end

    preload(8'd5, 32'h12345678);
    set_port(0, 1'b0, 8'd5, 32'h0, 4'h0);
    run_round(3'b001);

    set_port(1, 1'b1, 8'd9, 32'hCAFEF00D, 4'hF);
    run_round(3'b010);
    set_port(0, 1'b0, 8'd9, 32'h0, 4'h0);
    run_round(3'b001);

    preload(8'd3, 32'hAABBCCDD);
    set_port(1, 1'b1, 8'd3, 32'h00000011, 4'h1);
    run_round(3'b010);
    set_port(1, 1'b1, 8'd3, 32'h00002233, 4'h3);
    run_round(3'b010);
    checks++;
    if (ram[3] !== 32'hAABB2233) begin
      errors++;
      $display("FAIL partial_merge: mem[3]=%h, required aabb2233", ram[3]);
    end

    for (int k = 0; k < 2; k++) begin
      set_port(0, 1'b0, 8'd5, 32'h0, 4'h0);
      set_port(1, 1'b0, 8'd9, 32'h0, 4'h0);
      set_port(2, 1'b0, 8'd3, 32'h0, 4'h0);
      run_round(3'b111);
    end

    set_port(2, 1'b1, 8'd5, 32'hFFFFFFFF, 4'h0);
    run_round(3'b100);

    // Reset during the RD cycle of a partial write: aborted, no write.
    wr0 = wr_cnt;
    set_port(1, 1'b1, 8'd3, 32'h000000EE, 4'h1);
    bus.req = 3'b010;
    tick();
    rstn = 1'b0;
    tick();
    bus.req   = '0;
    rstn      = 1'b1;
    mdl_last  = N - 1;
    mdl_rdata = '0;
    repeat (3) tick();
    checks++;
    if (bus.gnt !== '0 || bus.busy !== 1'b0 || bus.ack !== '0 || wr_cnt != wr0 || ram[3] !== mdl_mem[3]) begin
      errors++;
      $display("FAIL reset_in_rd: gnt=%b busy=%b ack=%b writes=%0d mem3=%h, required 0 0 0 0 %h",
               bus.gnt, bus.busy, bus.ack, wr_cnt - wr0, ram[3], mdl_mem[3]);
    end

    // Reset during the WR cycle of a full write: the write still lands.
    set_port(1, 1'b1, 8'd9, 32'hDEADBEEF, 4'hF);
    bus.req = 3'b010;
    tick();
    rstn = 1'b0;
    tick();
    bus.req    = '0;
    rstn       = 1'b1;
    mdl_last   = N - 1;
    mdl_rdata  = '0;
    mdl_mem[9] = 32'hDEADBEEF;
    repeat (3) tick();
    checks++;
    if (ram[9] !== 32'hDEADBEEF || bus.gnt !== '0 || bus.busy !== 1'b0 || bus.ack !== '0 ||
        ram_wr_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_wr: mem9=%h gnt=%b busy=%b ack=%b wen=%b, required deadbeef 0 0 0 0",
               ram[9], bus.gnt, bus.busy, bus.ack, ram_wr_enable);
    end
    set_port(0, 1'b0, 8'd3, 32'h0, 4'h0);
    set_port(1, 1'b0, 8'd9, 32'h0, 4'h0);
    run_round(3'b011);

    for (int n = 0; n < 40; n++) begin
      m = N'($urandom_range(1, 7));
      for (int p = 0; p < N; p++) begin
        r = $urandom_range(0, 3);
        b = (r == 0) ? 4'hF : (r == 1) ? 4'h0 : BW'($urandom);
        set_port(p, 1'($urandom), AW'($urandom_range(0, 15)), $urandom, b);
      end
      run_round(m);
    end

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected acks never seen, required 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single word-wide RAM between up to N requesters: instruction fetch, load/store data port, and a debug/boot loader port.
- Arbitration is round-robin, with a req/gnt/ack handshake per port.
- Sub-word (byte/halfword) stores are done as read-modify-write, because the RAM only supports whole-word writes.
- Sits between the CPU sequencing logic and the ram instance. It is the only driver of the RAM ports.

Parameters:
- N_PORTS, 3, number of requesters; port 0 = fetch, 1 = data, 2 = loader.
- ADDR_WIDTH, 8, RAM word-address width.
- WIDTH, 32, data word width; byte-enable width is WIDTH/8.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- req  in  N_PORTS  per-port request; held high until ack
- we  in  N_PORTS  per-port write (1) / read (0)
- addr  in  N_PORTS*ADDR_WIDTH  flattened word addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- wdata  in  N_PORTS*WIDTH  flattened write data
- be  in  N_PORTS*WIDTH/8  flattened byte enables; bit k covers byte k
- gnt  out  N_PORTS  one-hot, high for the owning port from the cycle after grant to ACK inclusive
- ack  out  N_PORTS  one-cycle completion pulse for the owning port
- rdata  out  WIDTH  read data, valid while ack is high (shared by all ports)
- busy  out  1  high in any state other than IDLE
- ram_wr_enable  out  1  RAM write strobe
- ram_rd_addr  out  ADDR_WIDTH  RAM read address
- ram_wr_addr  out  ADDR_WIDTH  RAM write address
- ram_data_in  out  WIDTH  RAM write data
- ram_data_out  in  WIDTH  RAM combinational read data

Behaviour:
- Reset and clocking: rstn is synchronous, active-low; clock is clk. All outputs are registered.
- Reset values: gnt=0, ack=0, rdata=0, busy=0, ram_wr_enable=0, ram_rd_addr=0, ram_wr_addr=0, ram_data_in=0. State=IDLE, last_grant=N_PORTS-1, so port 0 wins first.
- States: IDLE, RD, WR, ACK.
- IDLE: if any req is high, grant the first requesting port scanning upward from last_grant+1 (mod N_PORTS). Then:
  - latch port id, we, addr, wdata, be;
  - set ram_rd_addr = ram_wr_addr = addr;
  - update last_grant;
  - set gnt for that port.
- IDLE next-state:
  - we=1 and be all ones: ram_data_in=wdata, ram_wr_enable=1, go to WR.
  - Otherwise: go to RD.
- RD: capture ram_data_out.
  - Read (we=0): rdata=ram_data_out, go to ACK.
  - Partial write: merge per byte (be[k] ? wdata byte k : ram_data_out byte k) into ram_data_in, set ram_wr_enable=1, go to WR.
  - we=1 with be=0: no write; go to ACK.
- WR: the RAM commits at the end of this cycle. Drop ram_wr_enable, go to ACK.
- ACK: ack[port]=1 for exactly one cycle, rdata held. Next cycle: gnt=0, go to IDLE. No new grant is made in ACK, which gives a one-cycle bubble between transactions.
- Latency (request first seen in IDLE at cycle 0):
  - read: ack at cycle 2;
  - full-word write: committed at end of cycle 1, ack at cycle 2;
  - partial write: committed at end of cycle 2, ack at cycle 3.
- Hazard-free by construction: only one transaction is outstanding. A read issued after a write's ack sees the new data.
- Request inputs are sampled only in IDLE. Changes to we/addr/wdata/be after grant are ignored. A req that drops mid-transaction does not abort it; ack is still issued.
- A requester must drop req in the cycle after it sees ack. If req is still high in the following IDLE, it is treated as a new request.
- Fairness: with all ports requesting continuously, grants rotate 0,1,2,0,... Any requester is granted within N_PORTS-1 other transactions.
- rdata changes only on read completion. After writes it keeps its last value.
- Reset mid-operation: return to IDLE with reset values; no ack is issued. A write whose WR cycle coincides with rstn=0 still commits, because the RAM samples the already-high ram_wr_enable. Earlier states abort with no RAM write.
- Address arithmetic: none; the word address is passed through unmodified.

Test Plan:
- Preload mem[5]=0x12345678; port 0 reads addr 5 -> gnt[0]=1 at cycles 1-2, ack[0] at cycle 2, rdata=0x12345678.
- Port 1 writes addr 9, wdata 0xCAFEF00D, be=4'hF -> ram_wr_enable=1 in cycle 1 only, ack[1] at cycle 2; a subsequent read of addr 9 returns 0xCAFEF00D.
- mem[3]=0xAABBCCDD; port 1 writes wdata 0x00000011, be=4'h1 -> ack at cycle 3, mem[3]=0xAABBCC11. Then with be=4'h3 and wdata 0x00002233 -> mem[3]=0xAABB2233.
- All three req held high continuously -> grant order 0,1,2,0,1,2; each transaction is followed by one idle bubble; no port waits more than 2 transactions.
- Port 2 write, be=4'h0 -> no ram_wr_enable pulse, ack[2] at cycle 2, memory unchanged.
- rstn low during the RD cycle of a partial write -> next cycle state IDLE, gnt=0, ack never pulses, memory unchanged. rstn low during WR -> write commits, no ack.
